// File: rtl/serial_bit_source_pkg.sv
// serial_src_pkg: shared definitions for the serial bit source and its
// counter sub-module.
//   - state_e: 2-bit FSM state encoding (ST_IDLE, ST_SHIFT, ST_PARITY)
//   - DEFAULT_WIDTH: default parallel word width
//   - clog2(): ceiling log2, used to size the bit counter
package serial_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Smallest r with 2**r >= value. This is enough to hold the
  // counter reload value (value-1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_bit_source_if.sv
// serial_bit_source_if: word-in / bit-out signal bundle.
//   din, din_valid, din_ready : parallel word handshake
//   sout, sout_valid          : serial bit stream, MSB first
//   busy, word_done           : status (word in flight, last-bit pulse)
// Modports: master drives words in and observes the stream; slave is the
// serializer.
interface serial_bit_source_if
  import serial_src_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             word_done;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, busy, word_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, busy, word_done
  );
endinterface

// File: rtl/serial_bit_source_ser_bit_cnt.sv
// ser_bit_cnt: loadable down-counter with zero flag.
// Ports:
//   clk, reset : clock, async active-high reset (count -> 0)
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; holds at zero, never wraps
//   count      : current count
//   is_zero    : count == 0
module ser_bit_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             is_zero
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count   = cnt_q;
  assign is_zero = (cnt_q == '0);
endmodule

// File: rtl/serial_bit_source.sv
// serial_bit_source: serializes parallel words MSB-first, one bit per clk,
// feeding the overlapping 1010 detector. Back-to-back words stream with no
// gap cycle.
// Ports:
//   clk   : system clock, rising edge
//   reset : async active-high reset
//   bus   : serial_bit_source_if.slave (din/din_valid/din_ready in,
//           sout/sout_valid/busy/word_done out)
// Parameters: WIDTH (2..32), IDLE_BIT (sout level when no bit is sent).
// Optional feature macro SERIAL_SRC_PARITY_EN: appends one even-parity bit
// after each word (PARITY state).
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | nothing in flight, ready for a word
// ST_SHIFT  | data bit shreg[MSB] on sout, cnt bits remain after it
// ST_PARITY | parity bit on sout (SERIAL_SRC_PARITY_EN only)
module serial_bit_source
  import serial_src_pkg::*;
#(
  parameter int   WIDTH    = DEFAULT_WIDTH,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  serial_bit_source_if.slave  bus
);
  localparam int               CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             busy_q, busy_d;
  logic             word_done_q, word_done_d;
`ifdef SERIAL_SRC_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             din_ready;
  logic             accept;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  ser_bit_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_LAST),
    .dec      (cnt_dec),
    .count    (cnt),
    .is_zero  (cnt_zero)
  );

  // Ready on the cycle that frees the shifter so the next word follows
  // with no gap: the last data bit, or the parity bit when enabled.
  always_comb begin
    din_ready = 1'b0;
    case (state_q)
      ST_IDLE: din_ready = 1'b1;
`ifdef SERIAL_SRC_PARITY_EN
      ST_PARITY: din_ready = 1'b1;
`else
      ST_SHIFT: din_ready = cnt_zero;
`endif
      default: din_ready = 1'b0;
    endcase
  end

  assign accept = bus.din_valid & din_ready;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_zero) begin
`ifdef SERIAL_SRC_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = accept ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef SERIAL_SRC_PARITY_EN
      ST_PARITY: state_d = accept ? ST_SHIFT : ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: din is captured only on the accept edge.
  always_comb begin
    shreg_d  = shreg_q;
    cnt_load = accept;
    cnt_dec  = 1'b0;
    if (accept) begin
      shreg_d = bus.din;
    end else if (state_q == ST_SHIFT) begin
      shreg_d = shreg_q << 1;
      cnt_dec = 1'b1;
    end
`ifdef SERIAL_SRC_PARITY_EN
    parity_d = accept ? ^bus.din : parity_q;
`endif
  end

  // Outputs are registered from next-state values so each one lines up
  // with the state it describes.
  always_comb begin
    sout_d       = IDLE_BIT;
    sout_valid_d = 1'b0;
    busy_d       = (state_d != ST_IDLE);
    word_done_d  = 1'b0;
    case (state_d)
      ST_SHIFT: begin
        sout_d       = shreg_d[WIDTH-1];
        sout_valid_d = 1'b1;
`ifndef SERIAL_SRC_PARITY_EN
        // Counter reaches zero next cycle: that is the last data bit.
        word_done_d  = !accept && (cnt == CNT_W'(1));
`endif
      end
`ifdef SERIAL_SRC_PARITY_EN
      ST_PARITY: begin
        sout_d       = parity_d;
        sout_valid_d = 1'b1;
        word_done_d  = 1'b1;
      end
`endif
      default: begin
        sout_d       = IDLE_BIT;
        sout_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      sout_q       <= IDLE_BIT;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      word_done_q  <= 1'b0;
`ifdef SERIAL_SRC_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
      word_done_q  <= word_done_d;
`ifdef SERIAL_SRC_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.word_done  = word_done_q;
endmodule

// File: tb/tb_serial_bit_source.sv
// Directed bench for serial_bit_source at WIDTH=4, IDLE_BIT=0.
// Each cycle the observed vector is {din_ready, sout, sout_valid, busy,
// word_done}. Builds with or without SERIAL_SRC_PARITY_EN.
module tb_serial_bit_source;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  serial_bit_source_if #(.WIDTH(4)) bus ();

  serial_bit_source #(.WIDTH(4), .IDLE_BIT(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [4:0] obs;
  assign obs = {bus.din_ready, bus.sout, bus.sout_valid, bus.busy, bus.word_done};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.din = 4'b0000;
    bus.din_valid = 1'b0;
    tick;
    tick;
    n_checks++;
    if (obs !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_held: got %b want %b", obs, 5'b10000);
    end
    @(negedge clk);
    reset = 1'b0;
    tick;
    n_checks++;
    if (obs !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_released: got %b want %b", obs, 5'b10000);
    end
  endtask

`ifndef SERIAL_SRC_PARITY_EN
  task automatic test_single_word;
    logic [4:0] exp [$];
    exp = '{5'b01110, 5'b00110, 5'b01110, 5'b10111, 5'b10000, 5'b10000};
    bus.din = 4'b1010;
    bus.din_valid = 1'b1;
    tick;
    bus.din_valid = 1'b0;
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL single_word cycle %0d: got %b want %b", i, obs, exp[i]);
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp [$];
    exp = '{5'b01110, 5'b01110, 5'b00110, 5'b11111,
            5'b00110, 5'b01110, 5'b00110, 5'b11111, 5'b10000};
    bus.din = 4'b1101;
    bus.din_valid = 1'b1;
    n_checks++;
    if (obs !== 5'b10000) begin
      n_fail++;
      $display("FAIL b2b_accept_cycle: got %b want %b", obs, 5'b10000);
    end
    tick;
    bus.din = 4'b0101;
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %b want %b", i, obs, exp[i]);
      end
      tick;
      if (i == 3) bus.din_valid = 1'b0;
    end
  endtask
`else
  task automatic test_parity_single;
    logic [4:0] exp [$];
    exp = '{5'b01110, 5'b00110, 5'b01110, 5'b01110, 5'b11111, 5'b10000};
    bus.din = 4'b1011;
    bus.din_valid = 1'b1;
    tick;
    bus.din_valid = 1'b0;
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL parity_single cycle %0d: got %b want %b", i, obs, exp[i]);
      end
      tick;
    end
  endtask

  task automatic test_parity_back_to_back;
    logic [4:0] exp [$];
    exp = '{5'b01110, 5'b00110, 5'b00110, 5'b00110, 5'b11111,
            5'b00110, 5'b00110, 5'b00110, 5'b01110, 5'b11111, 5'b10000};
    bus.din = 4'b1000;
    bus.din_valid = 1'b1;
    tick;
    bus.din = 4'b0001;
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL parity_b2b cycle %0d: got %b want %b", i, obs, exp[i]);
      end
      tick;
      if (i == 4) bus.din_valid = 1'b0;
    end
  endtask
`endif

  task automatic test_din_change;
    logic [4:0] exp [$];
`ifdef SERIAL_SRC_PARITY_EN
    exp = '{5'b01110, 5'b00110, 5'b01110, 5'b00110, 5'b10111, 5'b10000};
`else
    exp = '{5'b01110, 5'b00110, 5'b01110, 5'b10111, 5'b10000};
`endif
    bus.din = 4'b1010;
    bus.din_valid = 1'b1;
    tick;
    bus.din = 4'b0000;
    bus.din_valid = 1'b0;
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL din_change cycle %0d: got %b want %b", i, obs, exp[i]);
      end
      tick;
    end
  endtask

  task automatic test_mid_reset;
    logic [4:0] exp [$];
`ifdef SERIAL_SRC_PARITY_EN
    exp = '{5'b01110, 5'b00110, 5'b00110, 5'b00110, 5'b11111, 5'b10000};
`else
    exp = '{5'b01110, 5'b00110, 5'b00110, 5'b10111, 5'b10000};
`endif
    bus.din = 4'b1111;
    bus.din_valid = 1'b1;
    tick;
    bus.din_valid = 1'b0;
    n_checks++;
    if (obs !== 5'b01110) begin
      n_fail++;
      $display("FAIL mid_reset_bit0: got %b want %b", obs, 5'b01110);
    end
    tick;
    n_checks++;
    if (obs !== 5'b01110) begin
      n_fail++;
      $display("FAIL mid_reset_bit1: got %b want %b", obs, 5'b01110);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 5'b10000) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %b want %b", obs, 5'b10000);
    end
    tick;
    @(negedge clk);
    reset = 1'b0;
    tick;
    n_checks++;
    if (obs !== 5'b10000) begin
      n_fail++;
      $display("FAIL mid_reset_after: got %b want %b", obs, 5'b10000);
    end
    bus.din = 4'b1000;
    bus.din_valid = 1'b1;
    tick;
    bus.din_valid = 1'b0;
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL post_reset_word cycle %0d: got %b want %b", i, obs, exp[i]);
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
`ifdef SERIAL_SRC_PARITY_EN
    test_parity_single;
    test_parity_back_to_back;
`else
    test_single_word;
    test_back_to_back;
`endif
    test_din_change;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
